// File: rtl/axi_bram_log_drain.sv
// Drains N logged entries from the AXI BRAM logger's 32-bit read port into a
// valid/ready word stream, then pulses the logger's clear input.
module axi_bram_log_drain #(
  parameter int NUM_SER_BRAMS = 12,
  parameter int NUM_PAR_BRAMS = 3,
  parameter int FIFO_DEPTH    = 4,
  parameter int CNT_BITW      = $clog2(1024 * NUM_SER_BRAMS) + 1
) (
  input  logic                Clk_CI,
  input  logic                Rst_RBI,
  input  logic                Start_SI,
  input  logic [CNT_BITW-1:0] NumEntries_DI,
  output logic                Busy_SO,
  output logic                Done_SO,
  output logic                ClearLog_SO,
  output logic                BramEn_SO,
  output logic [31:0]         BramAddr_DO,
  output logic [3:0]          BramWrEn_SO,
  output logic [31:0]         BramWr_DO,
  input  logic [31:0]         BramRd_DI,
  output logic [31:0]         OutData_DO,
  output logic                OutValid_SO,
  input  logic                OutReady_SI,
  output logic                OutLast_SO
);

  localparam int CAP = 1024 * NUM_SER_BRAMS;
  localparam int TW  = CNT_BITW + 2;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, READ, FLUSH, CLEAR} state_e;

  state_e              state_q, state_d;
  logic [TW-1:0]       tot_words_q, rd_idx_q, pop_cnt_q, last_idx;
  logic [31:0]         last_addr_q, rd_addr;
  logic                rd_pend_q;
  logic [31:0]         fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [OW-1:0]       occ_q;
  logic [CNT_BITW-1:0] n_cap;
  logic [TW-1:0]       n_words;
  logic                rd_en, push, pop, fifo_empty, start_ok;

  assign n_cap   = (NumEntries_DI > CNT_BITW'(CAP)) ? CNT_BITW'(CAP) : NumEntries_DI;
  assign n_words = TW'(n_cap) * TW'(NUM_PAR_BRAMS);
  assign last_idx = tot_words_q - TW'(1);
  assign start_ok = (state_q == IDLE) && Start_SI;

  // Credits cover both buffered words and the read whose data is still on
  // its way back, so a push can never find the FIFO full.
  assign fifo_empty = (occ_q == '0);
  assign rd_en      = (state_q == READ) && ((int'(occ_q) + int'(rd_pend_q)) < FIFO_DEPTH);
  assign push       = rd_pend_q;
  assign pop        = !fifo_empty && OutReady_SI;

  assign rd_addr     = 32'({rd_idx_q, 2'b00});
  assign BramEn_SO   = rd_en;
  assign BramAddr_DO = rd_en ? rd_addr : last_addr_q;
  assign BramWrEn_SO = '0;
  assign BramWr_DO   = '0;

  // Gated so the unreset storage never shows through while empty.
  assign OutValid_SO = !fifo_empty;
  assign OutData_DO  = fifo_empty ? '0 : fifo_mem[rd_ptr_q];
  assign OutLast_SO  = !fifo_empty && (pop_cnt_q == last_idx);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    Busy_SO     = (state_q != IDLE);
    Done_SO     = 1'b0;
    ClearLog_SO = 1'b0;
    case (state_q)
      IDLE:  if (Start_SI) state_d = (n_cap != '0) ? READ : CLEAR;
      READ:  if (rd_en && (rd_idx_q == last_idx)) state_d = FLUSH;
      FLUSH: if (fifo_empty && !rd_pend_q) state_d = CLEAR;
      CLEAR: begin
        Done_SO     = 1'b1;
        ClearLog_SO = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      state_q     <= IDLE;
      tot_words_q <= '0;
      rd_idx_q    <= '0;
      pop_cnt_q   <= '0;
      last_addr_q <= '0;
      rd_pend_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= rd_en;
      if (start_ok) begin
        tot_words_q <= n_words;
        rd_idx_q    <= '0;
        pop_cnt_q   <= '0;
      end
      if (rd_en) begin
        rd_idx_q    <= rd_idx_q + TW'(1);
        last_addr_q <= rd_addr;
      end
      if (push) wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_q  <= (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        pop_cnt_q <= pop_cnt_q + TW'(1);
      end
      occ_q <= occ_q + OW'(push) - OW'(pop);
    end
  end

  // NOTE: the FIFO storage is deliberately not reset; occupancy and pointers
  // define validity, and the output is masked while empty.
  always_ff @(posedge Clk_CI) begin
    if (push) fifo_mem[wr_ptr_q] <= BramRd_DI;
  end

endmodule

// File: doc/axi_bram_log_drain.md
# axi_bram_log_drain

Read-out engine that sits directly downstream of the AXI BRAM logger. On a start pulse it reads N logged 96-bit entries through the logger's 32-bit external BRAM port and streams them out as 32-bit words over a valid/ready interface. Once the last word has been accepted, it pulses the logger's clear input so that logging restarts at entry 0. It also provides backpressure-safe buffering between the fixed-latency BRAM and the stream consumer.

## Interface
Parameters:
- NUM_SER_BRAMS, 12, serial BRAM depth of the logger; capacity CAP = 1024*NUM_SER_BRAMS entries
- NUM_PAR_BRAMS, 3, 32-bit words per entry (W)
- FIFO_DEPTH, 4, output buffer depth in words; must be ≥ 2
- CNT_BITW, log2(CAP)+1, width of the entry-count input

Ports:
- Clk_CI  in  1  clock
- Rst_RBI  in  1  reset, synchronous, active-low
- Start_SI  in  1  single-cycle drain request; ignored while Busy_SO = 1
- NumEntries_DI  in  CNT_BITW  number of entries to drain, sampled with Start_SI
- Busy_SO  out  1  drain in progress
- Done_SO  out  1  one-cycle pulse when the drain has completed
- ClearLog_SO  out  1  one-cycle pulse; drives the logger's Clear_SI
- BramEn_SO  out  1  BRAM read enable
- BramAddr_DO  out  32  BRAM byte address
- BramWrEn_SO  out  4  byte write enables; constant 0
- BramWr_DO  out  32  write data; constant 0
- BramRd_DI  in  32  read data; valid exactly 1 cycle after BramEn_SO
- OutData_DO  out  32  stream data
- OutValid_SO  out  1  stream valid
- OutReady_SI  in  1  stream ready
- OutLast_SO  out  1  marks the final word of the drain

## Operation
- FSM states:
  - IDLE: Start_SI=1 latches Ncap = min(NumEntries_DI, CAP) and sets TotWords = Ncap*W. Go to READ if Ncap>0, else to CLEAR.
  - READ: issue reads; when the last read has been issued, go to FLUSH.
  - FLUSH: wait until the FIFO is empty and no read is in flight; then go to CLEAR.
  - CLEAR: assert ClearLog_SO and Done_SO for one cycle, then go to IDLE.
- Busy_SO = 1 in every state except IDLE.
- Read issue:
  - Word counter RdIdx runs 0..TotWords-1. BramAddr_DO = RdIdx<<2, so word k holds entry k/W, sub-word k%W, with sub-word 0 carrying the low bits (timestamp).
  - BramEn_SO is asserted only when FIFO occupancy + reads in flight < FIFO_DEPTH. This is the credit rule: the FIFO never overflows and returned data is never dropped.
- Return path: the cycle after a read is issued, BramRd_DI is pushed into the FIFO unconditionally.
- Output:
  - OutData_DO is the FIFO head; OutValid_SO = FIFO not empty.
  - A word is popped when OutValid_SO & OutReady_SI.
  - Push and pop in the same cycle are both allowed.
- OutLast_SO is 1 only while the head word is word TotWords-1. This is tracked by a popped-word counter compared against TotWords-1.
- BramAddr_DO holds its last value whenever BramEn_SO = 0.
- Width rule: TotWords is computed at CNT_BITW+2 bits, which is enough for CAP*3 with no overflow.

## Timing
- Reset values: Busy_SO, Done_SO, ClearLog_SO, BramEn_SO, OutValid_SO and OutLast_SO are 0; BramAddr_DO, BramWrEn_SO, BramWr_DO and OutData_DO are 0. The FIFO is empty, all counters are 0, and the state is IDLE.
- Start in cycle t:
  - Busy_SO=1 and the first BramEn_SO=1 (address 0) in cycle t+1.
  - First OutValid_SO in cycle t+3 (BRAM latency 1 + FIFO register 1).
- Throughput: with OutReady_SI held at 1, one word per cycle sustained. The final word is accepted in cycle t+2+TotWords.
- Completion: the cycle after FLUSH's exit condition holds, ClearLog_SO=Done_SO=1 for exactly one cycle. Busy_SO drops the cycle after that.
- Backpressure:
  - OutReady_SI=0 stalls reads once credits run out.
  - OutData_DO and OutLast_SO stay stable while OutValid_SO=1 and OutReady_SI=0.
- Start_SI while busy has no effect: no relatch and no restart.
- NumEntries_DI > CAP is clamped to CAP. NumEntries_DI = 0 means no BRAM access: CLEAR occurs in cycle t+1, Done_SO is asserted in t+1, and Busy_SO is asserted in t+1 only.
- Reset mid-drain (Rst_RBI=0 at any clock edge): return to the reset state at that edge. Any in-flight BRAM data is discarded, and no ClearLog_SO or Done_SO is generated.

## Test plan
- Preload 2 entries {0x11111111,0x22222222,0x33333333}, {0x44..,0x55..,0x66..}; Start with N=2 and ready=1 -> 6 words in order at addresses 0x0..0x14, OutLast_SO on the 0x66666666 word, one ClearLog_SO and Done_SO pulse.
- N=4, OutReady_SI toggling 1/0 on each cycle, then held at 0 for 10 cycles -> all 12 words appear exactly once and in order; BramEn_SO is stopped while occupancy+in-flight = 4; data stays stable while stalled.
- N=0 -> no BramEn_SO; ClearLog_SO and Done_SO at t+1; Busy_SO high for one cycle.
- N=0xFFFF with NUM_SER_BRAMS=12 -> clamped to 12288 entries; 36864 words; final address 0x23FFC.
- Rst_RBI low for one cycle during READ with 3 words buffered -> outputs return to reset values the next cycle; no Done_SO; a following Start with N=1 produces exactly 3 words.
- Start pulsed again during FLUSH -> ignored; a single Done_SO; word count unchanged.
